// File: rtl/pll_reconfig_ctrl.sv
// Reprograms an EG_PHY_PLL through its dynamic port from a table of divider profiles.
// Define PLL_RECFG_VERIFY_EN to add a readback-and-compare stage after the writes.
module pll_reconfig_ctrl #(
    parameter int unsigned       NUM_PROFILES = 4,
    parameter int unsigned       NUM_CH       = 4,
    parameter int unsigned       ADDR_W       = 6,
    parameter int unsigned       DATA_W       = 8,
    parameter logic [ADDR_W-1:0] REG_REFDIV   = ADDR_W'(0),
    parameter logic [ADDR_W-1:0] REG_FBDIV    = ADDR_W'(1),
    parameter logic [ADDR_W-1:0] REG_CH_BASE  = ADDR_W'(2),
    parameter int unsigned       RESET_CYCLES = 16,
    parameter int unsigned       LOCK_STABLE  = 64,
    parameter int unsigned       LOCK_TIMEOUT = 65535,
    localparam int unsigned      E            = NUM_CH + 2,
    localparam int unsigned      PW           = $clog2(NUM_PROFILES),
    localparam int unsigned      TW           = $clog2(NUM_PROFILES * E)
) (
    input  logic              dclk,
    input  logic              reset,
    input  logic              tbl_we,
    input  logic [TW-1:0]     tbl_addr,
    input  logic [DATA_W-1:0] tbl_wdata,
    input  logic              req,
    input  logic [PW-1:0]     profile_sel,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [1:0]        err_code,
    output logic              locked,
    output logic [ADDR_W-1:0] pll_daddr,
    output logic              pll_dcs,
    output logic              pll_dwe,
    output logic [DATA_W-1:0] pll_di,
    input  logic [DATA_W-1:0] pll_do,
    output logic              pll_reset,
    input  logic              pll_extlock
);

    localparam int unsigned DEPTH = NUM_PROFILES * E;
    localparam int unsigned TW1   = TW + 1;
    localparam int unsigned EW    = $clog2(E);
    localparam int unsigned CW_T  = $clog2(LOCK_TIMEOUT + 1);
    localparam int unsigned CW_R  = $clog2(RESET_CYCLES + 1);
    localparam int unsigned CW    = (CW_T > CW_R) ? CW_T : CW_R;
    localparam int unsigned SW    = $clog2(LOCK_STABLE + 1);
    localparam logic [TW:0] DEPTH_W = TW1'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ASSERT_RST,
        S_WRITE,
`ifdef PLL_RECFG_VERIFY_EN
        S_VERIFY,
`endif
        S_RELEASE,
        S_WAIT_LOCK
    } state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     prof_q, prof_d;
    logic [EW-1:0]     ent_q, ent_d;
    logic              ph_q, ph_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [SW-1:0]     stab_q, stab_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic [1:0]        err_code_q, err_code_d;
    logic              locked_q, locked_d;
    logic [ADDR_W-1:0] daddr_q, daddr_d;
    logic              dcs_q, dcs_d;
    logic              dwe_q, dwe_d;
    logic [DATA_W-1:0] di_q, di_d;
    logic              pll_reset_q, pll_reset_d;
    logic [DATA_W-1:0] tbl_q [DEPTH];
    logic [DATA_W-1:0] tbl_d [DEPTH];
    logic [EW-1:0]     ent_nx;

    function automatic logic [ADDR_W-1:0] ent_addr(input logic [EW-1:0] e);
        if (e == EW'(0))      return REG_REFDIV;
        else if (e == EW'(1)) return REG_FBDIV;
        else                  return REG_CH_BASE + ADDR_W'(e - EW'(2));
    endfunction

    function automatic logic [TW-1:0] tbl_idx(input logic [PW-1:0] p, input logic [EW-1:0] e);
        return TW'(p) * TW'(E) + TW'(e);
    endfunction

    assign ent_nx = ent_q + EW'(1);

    // Profile table: no reset, contents survive a controller reset.
    always_comb begin
        tbl_d = tbl_q;
        if (tbl_we && ({1'b0, tbl_addr} < DEPTH_W)) tbl_d[tbl_addr] = tbl_wdata;
    end

    always_ff @(posedge dclk) tbl_q <= tbl_d;

    always_comb begin
        state_d     = state_q;
        prof_d      = prof_q;
        ent_d       = ent_q;
        ph_d        = ph_q;
        cnt_d       = cnt_q;
        stab_d      = stab_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        error_d     = 1'b0;
        err_code_d  = err_code_q;
        locked_d    = locked_q;
        daddr_d     = daddr_q;
        dcs_d       = 1'b0;
        dwe_d       = 1'b0;
        di_d        = di_q;
        pll_reset_d = pll_reset_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    state_d     = S_ASSERT_RST;
                    prof_d      = profile_sel;
                    err_code_d  = 2'd0;
                    busy_d      = 1'b1;
                    pll_reset_d = 1'b1;
                    locked_d    = 1'b0;
                    cnt_d       = '0;
                end else if (!pll_extlock) begin
                    locked_d = 1'b0;
                end
            end
            S_ASSERT_RST: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(RESET_CYCLES - 1)) begin
                    state_d = S_WRITE;
                    ent_d   = '0;
                    ph_d    = 1'b0;
                    dcs_d   = 1'b1;
                    dwe_d   = 1'b1;
                    daddr_d = ent_addr('0);
                    di_d    = tbl_q[tbl_idx(prof_q, '0)];
                end
            end
            // Each entry is a strobe cycle followed by a gap cycle.
            S_WRITE: begin
                if (!ph_q) begin
                    ph_d = 1'b1;
                end else if (ent_q == EW'(E - 1)) begin
`ifdef PLL_RECFG_VERIFY_EN
                    state_d = S_VERIFY;
                    ent_d   = '0;
                    ph_d    = 1'b0;
                    dcs_d   = 1'b1;
                    daddr_d = ent_addr('0);
`else
                    state_d     = S_RELEASE;
                    pll_reset_d = 1'b0;
`endif
                end else begin
                    ent_d   = ent_nx;
                    ph_d    = 1'b0;
                    dcs_d   = 1'b1;
                    dwe_d   = 1'b1;
                    daddr_d = ent_addr(ent_nx);
                    di_d    = tbl_q[tbl_idx(prof_q, ent_nx)];
                end
            end
`ifdef PLL_RECFG_VERIFY_EN
            // Readback lands on pll_do in the cycle after the read strobe.
            S_VERIFY: begin
                if (!ph_q) begin
                    ph_d = 1'b1;
                end else if (pll_do != tbl_q[tbl_idx(prof_q, ent_q)]) begin
                    state_d    = S_IDLE;
                    error_d    = 1'b1;
                    err_code_d = 2'd2;
                    busy_d     = 1'b0;
                end else if (ent_q == EW'(E - 1)) begin
                    state_d     = S_RELEASE;
                    pll_reset_d = 1'b0;
                end else begin
                    ent_d   = ent_nx;
                    ph_d    = 1'b0;
                    dcs_d   = 1'b1;
                    daddr_d = ent_addr(ent_nx);
                end
            end
`endif
            S_RELEASE: begin
                state_d = S_WAIT_LOCK;
                cnt_d   = '0;
                stab_d  = '0;
            end
            S_WAIT_LOCK: begin
                cnt_d  = cnt_q + CW'(1);
                stab_d = pll_extlock ? stab_q + SW'(1) : '0;
                if (pll_extlock && (stab_q == SW'(LOCK_STABLE - 1))) begin
                    state_d  = S_IDLE;
                    done_d   = 1'b1;
                    locked_d = 1'b1;
                    busy_d   = 1'b0;
                end else if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
                    state_d    = S_IDLE;
                    error_d    = 1'b1;
                    err_code_d = 2'd1;
                    busy_d     = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifndef PLL_RECFG_VERIFY_EN
    logic unused_pll_do;
    assign unused_pll_do = ^pll_do;
`endif

    always_ff @(posedge dclk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            prof_q      <= '0;
            ent_q       <= '0;
            ph_q        <= 1'b0;
            cnt_q       <= '0;
            stab_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            err_code_q  <= 2'd0;
            locked_q    <= 1'b0;
            daddr_q     <= '0;
            dcs_q       <= 1'b0;
            dwe_q       <= 1'b0;
            di_q        <= '0;
            pll_reset_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            prof_q      <= prof_d;
            ent_q       <= ent_d;
            ph_q        <= ph_d;
            cnt_q       <= cnt_d;
            stab_q      <= stab_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            err_code_q  <= err_code_d;
            locked_q    <= locked_d;
            daddr_q     <= daddr_d;
            dcs_q       <= dcs_d;
            dwe_q       <= dwe_d;
            di_q        <= di_d;
            pll_reset_q <= pll_reset_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;
    assign err_code  = err_code_q;
    assign locked    = locked_q;
    assign pll_daddr = daddr_q;
    assign pll_dcs   = dcs_q;
    assign pll_dwe   = dwe_q;
    assign pll_di    = di_q;
    assign pll_reset = pll_reset_q;

endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// Scoreboard bench for pll_reconfig_ctrl: stimulus queues expected write strobes and
// done/error pulses with their cycle numbers; a monitor pops and compares them.
`timescale 1ns/1ps
module tb_pll_reconfig_ctrl;

`ifdef PLL_RECFG_VERIFY_EN
    localparam int V = 12;
`else
    localparam int V = 0;
`endif

    logic       dclk = 1'b0;
    logic       reset;
    logic       tbl_we;
    logic [4:0] tbl_addr;
    logic [7:0] tbl_wdata;
    logic       req;
    logic [1:0] profile_sel;
    logic       busy, done, error, locked;
    logic [1:0] err_code;
    logic [5:0] pll_daddr;
    logic       pll_dcs, pll_dwe, pll_reset;
    logic [7:0] pll_di, pll_do;
    logic       pll_extlock;

    pll_reconfig_ctrl dut (
        .dclk(dclk), .reset(reset), .tbl_we(tbl_we), .tbl_addr(tbl_addr),
        .tbl_wdata(tbl_wdata), .req(req), .profile_sel(profile_sel),
        .busy(busy), .done(done), .error(error), .err_code(err_code),
        .locked(locked), .pll_daddr(pll_daddr), .pll_dcs(pll_dcs),
        .pll_dwe(pll_dwe), .pll_di(pll_di), .pll_do(pll_do),
        .pll_reset(pll_reset), .pll_extlock(pll_extlock)
    );

    always #5 dclk = ~dclk;

    typedef struct {
        int kind;   // 0 write strobe, 1 done, 2 error
        int addr;
        int data;
        int cyc;
        int code;
        int rst;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_miss = 0;
    int   cyc = 0;
    int   prof_tab [4][6];

    always @(posedge dclk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_ev(input int kind, input int c, input int code, input int rst);
        exp_t x;
        x.kind = kind; x.addr = 0; x.data = 0; x.cyc = c; x.code = code; x.rst = rst;
        sb.push_back(x);
    endtask

    // Monitor: every write strobe, done or error pulse must match the queue head.
    always @(negedge dclk) begin
        if (!reset) begin
            if (pll_dcs && pll_dwe) begin
                if (sb.size() == 0 || sb[0].kind != 0) begin
                    chk("unexpected_write_addr", int'(pll_daddr), -1);
                end else begin
                    mon_e = sb.pop_front();
                    chk("wr_addr", int'(pll_daddr), mon_e.addr);
                    chk("wr_data", int'(pll_di), mon_e.data);
                    chk("wr_cycle", cyc, mon_e.cyc);
                end
            end
            if (done) begin
                if (sb.size() == 0 || sb[0].kind != 1) begin
                    chk("unexpected_done_cycle", cyc, -1);
                end else begin
                    mon_e = sb.pop_front();
                    chk("done_cycle", cyc, mon_e.cyc);
                    chk("done_locked", int'(locked), 1);
                    chk("done_busy", int'(busy), 0);
                    chk("done_error", int'(error), 0);
                end
            end
            if (error) begin
                if (sb.size() == 0 || sb[0].kind != 2) begin
                    chk("unexpected_error_cycle", cyc, -1);
                end else begin
                    mon_e = sb.pop_front();
                    chk("err_cycle", cyc, mon_e.cyc);
                    chk("err_code", int'(err_code), mon_e.code);
                    chk("err_pll_reset", int'(pll_reset), mon_e.rst);
                    chk("err_busy", int'(busy), 0);
                end
            end
        end
    end

    // PLL model: register file, optional readback corruption of addr 3, extlock timing.
    logic [7:0] pll_regs [64];
    int         fall_cyc = 0;
    bit         fall_seen = 1'b0;
    logic       prev_rst = 1'b0;
    int         lock_mode = 0;   // 0 never, 1 lock 100 cycles after release, 2 same with glitch
    bit         corrupt = 1'b0;

    always @(negedge dclk) begin
        if (pll_reset) fall_seen = 1'b0;
        else if (prev_rst) begin
            fall_seen = 1'b1;
            fall_cyc  = cyc;
        end
        prev_rst = pll_reset;
        case (lock_mode)
            1:       pll_extlock = fall_seen && (cyc >= fall_cyc + 100);
            2:       pll_extlock = fall_seen && (cyc >= fall_cyc + 100) && (cyc != fall_cyc + 140);
            default: pll_extlock = 1'b0;
        endcase
        if (pll_dcs && pll_dwe) pll_regs[pll_daddr] = pll_di;
        if (pll_dcs && !pll_dwe)
            pll_do = pll_regs[pll_daddr] ^ ((corrupt && pll_daddr == 6'd3) ? 8'h01 : 8'h00);
    end

    task automatic check_reset_vals(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_error"}, int'(error), 0);
        chk({tag, "_err_code"}, int'(err_code), 0);
        chk({tag, "_locked"}, int'(locked), 0);
        chk({tag, "_pll_reset"}, int'(pll_reset), 0);
        chk({tag, "_dcs"}, int'(pll_dcs), 0);
        chk({tag, "_dwe"}, int'(pll_dwe), 0);
        chk({tag, "_daddr"}, int'(pll_daddr), 0);
        chk({tag, "_di"}, int'(pll_di), 0);
    endtask

    task automatic load_profile(input int p);
        for (int i = 0; i < 6; i++) begin
            @(posedge dclk); #1;
            tbl_we    = 1'b1;
            tbl_addr  = 5'(p * 6 + i);
            tbl_wdata = 8'(prof_tab[p][i]);
        end
        @(posedge dclk); #1;
        tbl_we = 1'b0;
    endtask

    // Pulses req and queues the first nwr write strobes (addresses 0..5 in entry order).
    task automatic issue_req(input int p, input int nwr, output int k);
        exp_t x;
        @(posedge dclk); #1;
        k = cyc;
        req = 1'b1;
        profile_sel = 2'(p);
        for (int i = 0; i < nwr; i++) begin
            x.kind = 0; x.addr = i; x.data = prof_tab[p][i];
            x.cyc = k + 17 + 2 * i; x.code = 0; x.rst = 0;
            sb.push_back(x);
        end
        @(posedge dclk); #1;
        req = 1'b0;
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) begin
            @(posedge dclk); #1;
        end
    endtask

    task automatic drain(input string name, input int limit);
        int t0;
        t0 = cyc;
        while (sb.size() > 0 && cyc < t0 + limit) @(negedge dclk);
        chk({name, "_pending_events"}, sb.size(), 0);
        sb.delete();
    endtask

    task automatic stray_req(input int at, input int p);
        wait_cyc(at);
        req = 1'b1;
        profile_sel = 2'(p);
        @(posedge dclk); #1;
        req = 1'b0;
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        prof_tab[0] = '{11, 12, 13, 14, 15, 16};
        prof_tab[1] = '{5, 24, 4, 16, 20, 8};
        prof_tab[2] = '{3, 40, 1, 2, 7, 9};
        prof_tab[3] = '{31, 32, 33, 34, 35, 36};
        for (int i = 0; i < 64; i++) pll_regs[i] = 8'h00;
        reset = 1'b1; tbl_we = 1'b0; tbl_addr = '0; tbl_wdata = '0;
        req = 1'b0; profile_sel = '0; pll_do = '0; pll_extlock = 1'b0;

        repeat (3) @(posedge dclk);
        #1 check_reset_vals("por");
        @(posedge dclk); #1 reset = 1'b0;
        for (int p = 0; p < 4; p++) load_profile(p);

        // Async reset in the middle of WRITE: only two strobes may appear.
        issue_req(1, 2, k);
        wait_cyc(k + 20);
        reset = 1'b1;
        @(negedge dclk);
        check_reset_vals("midwrite_rst");
        @(posedge dclk); #1 reset = 1'b0;
        drain("midwrite", 10);

        // Clean lock; a second req during busy must be ignored.
        lock_mode = 1;
        issue_req(1, 6, k);
        chk("req_busy", int'(busy), 1);
        chk("req_pll_reset", int'(pll_reset), 1);
        push_ev(1, k + 29 + V + 164, 0, 0);
        stray_req(k + 5, 2);
        drain("lock", 400);
        @(negedge dclk);
        chk("locked_hold", int'(locked), 1);
        lock_mode = 0;
        repeat (3) @(negedge dclk);
        chk("locked_drop", int'(locked), 0);
        chk("lock_err_code", int'(err_code), 0);

        // Extlock drops for one cycle at stable count 40.
        lock_mode = 2;
        issue_req(2, 6, k);
        chk("glitch_locked_at_start", int'(locked), 0);
        push_ev(1, k + 29 + V + 205, 0, 0);
        drain("glitch", 500);
        lock_mode = 0;
        repeat (3) @(negedge dclk);

`ifdef PLL_RECFG_VERIFY_EN
        // Readback of address 3 corrupted: error with code 2, PLL left in reset.
        corrupt = 1'b1;
        lock_mode = 1;
        issue_req(1, 6, k);
        push_ev(2, k + 37, 2, 1);
        stray_req(k + 20, 2);
        drain("verify", 200);
        repeat (3) @(negedge dclk);
        chk("verify_pll_reset_held", int'(pll_reset), 1);
        chk("verify_err_code_held", int'(err_code), 2);
        corrupt = 1'b0;
        lock_mode = 0;
`endif

        // Extlock never rises: lock timeout.
        lock_mode = 0;
        issue_req(0, 6, k);
        push_ev(2, k + 29 + V + 65536, 1, 0);
        drain("timeout", 70000);
        repeat (3) @(negedge dclk);
        chk("timeout_err_code_held", int'(err_code), 1);

        // Next accepted req clears err_code.
        lock_mode = 1;
        issue_req(3, 6, k);
        chk("err_code_cleared", int'(err_code), 0);
        push_ev(1, k + 29 + V + 164, 0, 0);
        drain("relock", 400);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
